// File: rtl/serializer_pkg.sv
// Shared definitions for the bit serializer: state encoding and its width.
package serializer_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;

endpackage

// File: rtl/byte_bit_serializer.sv
// Parallel-to-serial converter feeding a run-detect FSM through one-hot
// ONE/ZERO strobes. A word is captured on LOAD&READY and streamed one bit per
// cycle (MSB or LSB first); back-to-back words run with no bubble.
// Optional macro BYTE_BIT_SERIALIZER_GAP_EN inserts an all-zero GAP cycle
// after every bit.
module byte_bit_serializer
  import serializer_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [WIDTH-1:0] DIN,
  input  logic             LOAD,
  output logic             READY,
  output logic             ONE,
  output logic             ZERO,
  output logic             LAST
);

  localparam int             CW       = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  // Holds READY low until the first edge after reset release.
  logic             rdy_en_q;

  logic             cur_bit;
  logic             in_shift;
  logic             is_last;
  logic             accept;
  logic [WIDTH-1:0] shifted;

  // The bit under transmission always sits at the outgoing end of sreg_q.
  assign cur_bit  = MSB_FIRST ? sreg_q[WIDTH-1] : sreg_q[0];
  assign in_shift = (state_q == SHIFT);
  assign is_last  = in_shift && (cnt_q == CNT_LAST);
  assign shifted  = MSB_FIRST ? {sreg_q[WIDTH-2:0], 1'b0}
                              : {1'b0, sreg_q[WIDTH-1:1]};

  // Outputs decode registered state only, so DIN/LOAD never reach them.
  assign ONE  = in_shift &  cur_bit;
  assign ZERO = in_shift & ~cur_bit;
  assign LAST = is_last;

`ifdef BYTE_BIT_SERIALIZER_GAP_EN
  // After the last bit the counter has wrapped to 0; no other GAP sees 0.
  assign READY = rdy_en_q && ((state_q == IDLE) ||
                              ((state_q == GAP) && (cnt_q == '0)));
`else
  assign READY = rdy_en_q && ((state_q == IDLE) || is_last);
`endif

  assign accept = LOAD && READY;

  // State, counter and shift register with asynchronous clear.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      sreg_q   <= '0;
      rdy_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sreg_q   <= sreg_d;
      rdy_en_q <= 1'b1;
    end
  end

  // Next-state: load on accept, otherwise advance one bit per SHIFT cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sreg_d  = sreg_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          sreg_d  = DIN;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        sreg_d = shifted;
        if (is_last) begin
          cnt_d = '0;
`ifdef BYTE_BIT_SERIALIZER_GAP_EN
          state_d = GAP;
`else
          if (accept) begin
            sreg_d  = DIN;
            state_d = SHIFT;
          end else begin
            state_d = IDLE;
          end
`endif
        end else begin
          cnt_d = cnt_q + CW'(1);
`ifdef BYTE_BIT_SERIALIZER_GAP_EN
          state_d = GAP;
`endif
        end
      end
`ifdef BYTE_BIT_SERIALIZER_GAP_EN
      GAP: begin
        if (cnt_q == '0) begin
          if (accept) begin
            sreg_d  = DIN;
            state_d = SHIFT;
          end else begin
            state_d = IDLE;
          end
        end else begin
          state_d = SHIFT;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_byte_bit_serializer.sv
// Directed bench for byte_bit_serializer: MSB-first instance plus an
// LSB-first instance sharing clock and reset. Builds with or without
// BYTE_BIT_SERIALIZER_GAP_EN.
module tb_byte_bit_serializer;

  logic       CLK = 1'b0;
  logic       RESET;
  logic [7:0] DIN, DIN2;
  logic       LOAD, LOAD2;
  logic       READY, ONE, ZERO, LAST;
  logic       READY2, ONE2, ZERO2, LAST2;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  byte_bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut (
    .CLK(CLK), .RESET(RESET), .DIN(DIN), .LOAD(LOAD),
    .READY(READY), .ONE(ONE), .ZERO(ZERO), .LAST(LAST)
  );

  byte_bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_lsb (
    .CLK(CLK), .RESET(RESET), .DIN(DIN2), .LOAD(LOAD2),
    .READY(READY2), .ONE(ONE2), .ZERO(ZERO2), .LAST(LAST2)
  );

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s got %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic one, input logic zero,
                         input logic last, input logic ready);
    chk({tag, ".ONE"},   ONE,   one);
    chk({tag, ".ZERO"},  ZERO,  zero);
    chk({tag, ".LAST"},  LAST,  last);
    chk({tag, ".READY"}, READY, ready);
  endtask

  // Checks 8 bits on the MSB-first instance; seq[7] is expected first.
  // Returns while the LAST bit is showing.
  task automatic chk_word(input string tag, input logic [7:0] seq);
    logic b;
    for (int i = 0; i < 8; i++) begin
      b = seq[7-i];
      chk_out($sformatf("%s.b%0d", tag, i), b, ~b, i == 7, i == 7);
      if (i < 7) step();
    end
  endtask

  initial begin
    logic b;
    RESET = 1'b0; DIN = '0; LOAD = 1'b0; DIN2 = '0; LOAD2 = 1'b0;

    // Reset state
    step(); step();
    chk_out("rst", 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst.READY2", READY2, 1'b0);
    #2 RESET = 1'b1;
    step();
    chk_out("post_rst", 1'b0, 1'b0, 1'b0, 1'b1);

`ifdef BYTE_BIT_SERIALIZER_GAP_EN
    // A5 with gap cycles: 16 cycles, READY only in the final gap
    DIN = 8'hA5; LOAD = 1'b1;
    step();
    LOAD = 1'b0;
    for (int c = 0; c < 16; c++) begin
      if (c % 2 == 0) begin
        b = 8'hA5 >> (7 - c / 2);
        chk_out($sformatf("gap.c%0d", c), b, ~b, c == 14, 1'b0);
      end else begin
        chk_out($sformatf("gap.c%0d", c), 1'b0, 1'b0, 1'b0, c == 15);
      end
      step();
    end
    chk_out("gap.idle", 1'b0, 1'b0, 1'b0, 1'b1);
`else
    // A5 once: 1,0,1,0,0,1,0,1 then back to idle
    DIN = 8'hA5; LOAD = 1'b1;
    step();
    LOAD = 1'b0;
    chk_word("a5", 8'b1010_0101);
    step();
    chk_out("a5.idle", 1'b0, 1'b0, 1'b0, 1'b1);

    // FF then 00 loaded in the LAST cycle: no bubble
    DIN = 8'hFF; LOAD = 1'b1;
    step();
    LOAD = 1'b0;
    chk_word("ff", 8'b1111_1111);
    DIN = 8'h00; LOAD = 1'b1;
    step();
    LOAD = 1'b0;
    chk_word("00", 8'b0000_0000);
    step();
    chk_out("00.idle", 1'b0, 1'b0, 1'b0, 1'b1);

    // LOAD pulse with 3C during bit 3 of 96 is ignored
    DIN = 8'h96; LOAD = 1'b1;
    step();
    LOAD = 1'b0;
    for (int i = 0; i < 8; i++) begin
      b = 8'h96 >> (7 - i);
      chk_out($sformatf("ign.b%0d", i), b, ~b, i == 7, i == 7);
      if (i == 3) begin DIN = 8'h3C; LOAD = 1'b1; end
      step();
      LOAD = 1'b0;
    end
    chk_out("ign.idle0", 1'b0, 1'b0, 1'b0, 1'b1);
    step();
    chk_out("ign.idle1", 1'b0, 1'b0, 1'b0, 1'b1);

    // Reset mid-word of F0, then 0F serializes cleanly
    DIN = 8'hF0; LOAD = 1'b1;
    step();
    LOAD = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk_out($sformatf("f0.b%0d", i), 1'b1, 1'b0, 1'b0, 1'b0);
      if (i < 3) step();
    end
    #2 RESET = 1'b0;
    #1 chk_out("midrst", 1'b0, 1'b0, 1'b0, 1'b0);
    step(); step();
    RESET = 1'b1;
    step();
    chk_out("midrst.rel", 1'b0, 1'b0, 1'b0, 1'b1);
    step();
    chk_out("midrst.idle", 1'b0, 1'b0, 1'b0, 1'b1);
    DIN = 8'h0F; LOAD = 1'b1;
    step();
    LOAD = 1'b0;
    chk_word("0f", 8'b0000_1111);
    step();
    chk_out("0f.idle", 1'b0, 1'b0, 1'b0, 1'b1);

    // LSB-first instance with 01: ONE first, then seven ZEROs
    chk("lsb.READY", READY2, 1'b1);
    DIN2 = 8'h01; LOAD2 = 1'b1;
    step();
    LOAD2 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("lsb.b%0d.ONE", i),  ONE2,  i == 0);
      chk($sformatf("lsb.b%0d.ZERO", i), ZERO2, i != 0);
      chk($sformatf("lsb.b%0d.LAST", i), LAST2, i == 7);
      step();
    end
    chk("lsb.idle.ONE",   ONE2,   1'b0);
    chk("lsb.idle.ZERO",  ZERO2,  1'b0);
    chk("lsb.idle.READY", READY2, 1'b1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
